// File: rtl/misr_pkg.sv
// Shared types and default constants for the MISR BIST block.
package misr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPACT = 2'd1,
      CHECK   = 2'd2,
      DONE    = 2'd3
   } misr_state_t;

   localparam int                        MISR_DEF_WIDTH = 7;
   // x^7 + x^6 + 1, primitive, so the free-run period is 2^7-1
   localparam logic [MISR_DEF_WIDTH-1:0] MISR_DEF_POLY  = 7'b1100000;
   localparam logic [MISR_DEF_WIDTH-1:0] MISR_DEF_SEED  = 7'd1;

endpackage

// File: rtl/misr_bist_if.sv
// Control/data bundle between a BIST sequencer (master) and misr_bist (slave).
interface misr_bist_if #(
   parameter int WIDTH = 7,
   parameter int CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] len;
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic [WIDTH-1:0] golden;
   logic [WIDTH-1:0] signature;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH:0]   period;
   logic             period_valid;

   modport master (
      output start, len, data_in, data_valid, golden,
      input  signature, busy, done, pass, period, period_valid
   );

   modport slave (
      input  start, len, data_in, data_valid, golden,
      output signature, busy, done, pass, period, period_valid
   );
endinterface

// File: rtl/misr_core.sv
// Signature register with the MISR step function; load_seed has priority over enable.
module misr_core
   import misr_pkg::*;
#(
   parameter int               WIDTH = MISR_DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = MISR_DEF_POLY,
   parameter logic [WIDTH-1:0] SEED  = MISR_DEF_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_seed_i,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] sig_o
);

   logic [WIDTH-1:0] sig_q, sig_d, step;

   // shift up, parity of tapped bits into bit 0, then fold in the input word
   assign step = {sig_q[WIDTH-2:0], ^(sig_q & POLY)} ^ in_i;

   always_comb begin
      sig_d = sig_q;
      if (load_seed_i)   sig_d = SEED;
      else if (enable_i) sig_d = step;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sig_q <= SEED;
      else      sig_q <= sig_d;
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/misr_bist.sv
// MISR compaction controller: IDLE free-run, COMPACT len words, CHECK vs golden, DONE.
// Optional free-run period monitor enabled by defining MISR_PERIOD_MON_EN.
module misr_bist
   import misr_pkg::*;
#(
   parameter int               WIDTH = MISR_DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = MISR_DEF_POLY,
   parameter logic [WIDTH-1:0] SEED  = MISR_DEF_SEED,
   parameter int               CNT_W = 16
) (
   input logic        clk,
   input logic        rst,
   misr_bist_if.slave bus
);

   misr_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pass_q, pass_d;
   logic             load_seed, step_en;
   logic [WIDTH-1:0] step_in, sig;

   misr_core #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_core (
      .clk         (clk),
      .rst         (rst),
      .load_seed_i (load_seed),
      .enable_i    (step_en),
      .in_i        (step_in),
      .sig_o       (sig)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pass_d    = pass_q;
      load_seed = 1'b0;
      step_en   = 1'b0;
      step_in   = '0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               load_seed = 1'b1;
               cnt_d     = bus.len;
               pass_d    = 1'b0;
               state_d   = (bus.len == '0) ? CHECK : COMPACT;
            end else if (state_q == IDLE) begin
               step_en = 1'b1;
            end
         end
         COMPACT: begin
            if (bus.data_valid) begin
               step_en = 1'b1;
               step_in = bus.data_in;
               cnt_d   = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = CHECK;
            end
         end
         CHECK: begin
            pass_d  = (sig == bus.golden);
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.signature = sig;
   assign bus.busy      = (state_q == COMPACT) || (state_q == CHECK);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;

`ifdef MISR_PERIOD_MON_EN
   logic [WIDTH:0]   pcnt_q, period_q;
   logic             pvld_q;
   logic [WIDTH-1:0] idle_next;

   // post-step value of a free-run (zero input) step
   assign idle_next = {sig[WIDTH-2:0], ^(sig & POLY)};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_q   <= '0;
         period_q <= '0;
         pvld_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         if (bus.start) begin
            pcnt_q <= '0;
            pvld_q <= 1'b0;
         end else if (idle_next == SEED) begin
            period_q <= pcnt_q + 1'b1;
            pvld_q   <= 1'b1;
            pcnt_q   <= '0;
         end else begin
            pcnt_q <= pcnt_q + 1'b1;
         end
      end
   end

   assign bus.period       = period_q;
   assign bus.period_valid = pvld_q;
`else
   assign bus.period       = '0;
   assign bus.period_valid = 1'b0;
`endif

endmodule

// File: doc/misr_bist.md
# misr_bist

Parametrised multiple-input signature register (MISR) with a built-in compaction controller: it compacts a run-time-selected number of valid input words into a signature, compares it against a golden value, and reports pass/fail. When idle it free-runs as an LFSR so its sequence period can be checked in hardware. It generalises the fixed 7-bit MISR and is instantiated next to the arbiter/BIST logic under test.

## Interface
- WIDTH, 7: signature and data width (≥2).
- POLY, 7'b1100000: feedback tap mask. Bit i set means state bit i feeds the parity. The default is x^7+x^6+1, which is primitive.
- SEED, 1: reset/start value of the signature. Must be nonzero.
- CNT_W, 16: width of the length counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a compaction run. Honoured in IDLE and DONE only.
- len  in  CNT_W  number of valid words to compact. Sampled with start.
- data_in  in  WIDTH  word to compact.
- data_valid  in  1  data_in is valid this cycle.
- golden  in  WIDTH  expected signature. Sampled in CHECK.
- signature  out  WIDTH  current MISR state.
- busy  out  1  high in COMPACT and CHECK.
- done  out  1  high in DONE.
- pass  out  1  comparison result. Valid while done=1.
- period  out  WIDTH+1  measured free-run period.
- period_valid  out  1  period holds a measurement.

## Operation
- Step function: next[i] = sig[i-1] ^ in[i] for i≥1, and next[0] = ^(sig & POLY) ^ in[0].
- Reset (rst=0, async): state=IDLE, signature=SEED, busy=0, done=0, pass=0, period=0, period_valid=0, counter=0.
- IDLE:
  - Signature steps every cycle with in forced to 0 (free-run LFSR).
  - start=1: signature←SEED, counter←len, next state COMPACT. If len=0, next state is CHECK instead.
- COMPACT:
  - On data_valid=1: step with in=data_in, counter−1. When the counter goes 1→0, go to CHECK.
  - On data_valid=0: signature and counter hold.
  - start is ignored.
- CHECK: one cycle. pass←(signature==golden), then go to DONE. The signature holds.
- DONE:
  - signature, pass and done hold.
  - start=1 restarts exactly as from IDLE, clearing done and pass on the same edge.
  - There is no return to IDLE except through reset.
- Reset mid-run aborts immediately; all outputs take their reset values.

## Timing
- Everything is registered; there are no combinational input→output paths.
- start is sampled at edge E0. busy=1 from E0.
- With data_valid held high and len=L≥1, the last word is compacted at edge E(L) and the design enters CHECK. done and pass go high after edge E(L+1).
- With len=0, done goes high after E1.
- Each data_valid-low cycle adds one cycle of latency.
- busy falls on the same edge that done rises.
- The first free-run step is on the first rising edge after rst deasserts.

## Configuration
- MISR_PERIOD_MON_EN defined:
  - In IDLE, a WIDTH+1-bit counter increments on every step.
  - When the post-step signature equals SEED, period←counter+1, period_valid←1, and the counter clears.
  - Leaving IDLE clears the counter and period_valid; period keeps its last value.
- Undefined: period=0 and period_valid=0 constantly, and no counter is synthesised. Port list is unchanged.

## Structure
- Package misr_pkg holds:
  - state typedef misr_state_t {IDLE, COMPACT, CHECK, DONE};
  - default constants MISR_DEF_WIDTH=7, MISR_DEF_POLY, MISR_DEF_SEED.
- Sub-module misr_core (parameters WIDTH, POLY, SEED) is the register plus step function, with inputs load_seed, enable and in. misr_bist wraps it with the FSM, the length counter and the period monitor.

## Test plan
- Reset, then idle with MISR_PERIOD_MON_EN and defaults → period_valid rises after 127 steps with period=127; the sequence never reaches 0.
- start, len=3, data_valid=1, data_in=0 → signature 1→2→4→8. done=1 and busy=0 four cycles after start. golden=8 gives pass=1; golden=9 gives pass=0.
- start, len=1, data_in=7'h01 → signature=3, pass=1 with golden=3.
- len=3 with data_valid pattern 1,0,0,1,1 → the signature matches the no-gap run; done arrives two cycles later.
- len=0, golden=SEED → pass=1 two edges after start. A second start from DONE clears done on the same edge.
- rst asserted during COMPACT → outputs immediately return to reset values; after release, state is IDLE and the signature is SEED.
